// File: rtl/sid_audio_pkg.sv
// Shared types, frame geometry and bit selection
// for the SID I2S audio output path.
package sid_audio_pkg;

  localparam int FRAME_BITS = 32;
  localparam int SLOT_BITS  = 16;
  localparam int FRAME_W    = $clog2(FRAME_BITS);

  typedef logic [SLOT_BITS-1:0] sample_t;

  // f=1 carries the MSB; f=0 wraps to the LSB
  function automatic logic [3:0] bit_sel(input logic [FRAME_W-1:0] f);
    logic [FRAME_W-1:0] w_m;
    w_m = f - FRAME_W'(1);
    return 4'(SLOT_BITS - 1) - w_m[3:0];
  endfunction

endpackage

// File: rtl/sid_i2s_tx_if.sv
// Sample push bus from the filter/volume stage
// into the I2S transmitter (strobe, no ready).
interface sid_i2s_tx_if;
  import sid_audio_pkg::*;

  sample_t sample_in;
  logic    sample_valid;

  modport master (output sample_in, output sample_valid);
  modport slave  (input  sample_in, input  sample_valid);

endinterface

// File: rtl/sid_sample_fifo2.sv
// Two-entry sample buffer; a push into a full
// buffer replaces the newest entry.
module sid_sample_fifo2
  import sid_audio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  sample_t    i_data,
  input  logic       i_pop,
  input  logic       i_ovf_clr,
  output sample_t    o_head,
  output logic [1:0] o_level,
  output logic       o_ovf
);

  sample_t    r_e0;
  sample_t    r_e1;
  logic [1:0] r_level;
  logic       r_ovf;

  logic w_pop;
  logic w_full;
  logic w_set;

  assign w_pop  = i_pop && (r_level != 2'd0);
  assign w_full = (r_level == 2'd2);
  assign w_set  = i_push && w_full && !w_pop;

  // r_e0 always holds the oldest entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_level <= 2'd0;
    end else begin
      case ({w_pop, i_push})
        2'b10: begin
          r_e0    <= r_e1;
          r_level <= r_level - 2'd1;
        end
        2'b01: begin
          if (r_level == 2'd0) r_e0 <= i_data;
          else                 r_e1 <= i_data;
          if (!w_full) r_level <= r_level + 2'd1;
        end
        2'b11: begin
          if (w_full) begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end else begin
            r_e0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  // sticky overflow; a new event beats the clear
  always_ff @(posedge clk) begin
    if (rst)            r_ovf <= 1'b0;
    else if (w_set)     r_ovf <= 1'b1;
    else if (i_ovf_clr) r_ovf <= 1'b0;
  end

  assign o_head  = r_e0;
  assign o_level = r_level;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/sid_i2s_tx.sv
// I2S transmitter: bit clock divider, frame
// counter and serializer, mono sample on L and R.
module sid_i2s_tx
  import sid_audio_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  sid_i2s_tx_if.slave  s_in,
  input  logic         enable,
  input  logic         ovf_clr,
  output logic         i2s_bclk,
  output logic         i2s_lrck,
  output logic         i2s_sdata,
  output logic [1:0]   fifo_level,
  output logic         overflow,
  output logic         underrun
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]    r_div;
  logic                r_bclk;
  logic                r_lrck;
  logic                r_sdata;
  logic                r_und;
  logic [FRAME_W-1:0]  r_f;
  logic [SAMPLE_W-1:0] r_cur;

  logic               w_tc;
  logic               w_fall;
  logic               w_fetch;
  logic [FRAME_W-1:0] w_f_nx;
  sample_t            w_head;
  logic [1:0]         w_level;

  assign w_tc    = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_fall  = enable && w_tc && r_bclk;
  assign w_f_nx  = r_f + FRAME_W'(1);
  assign w_fetch = w_fall && (w_f_nx == FRAME_W'(1));

  sid_sample_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (s_in.sample_valid),
    .i_data    (s_in.sample_in),
    .i_pop     (w_fetch),
    .i_ovf_clr (ovf_clr),
    .o_head    (w_head),
    .o_level   (w_level),
    .o_ovf     (overflow)
  );

  // divider, frame counter and serializer; frame abandoned when disabled
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_div   <= '0;
      r_bclk  <= 1'b0;
      r_f     <= '0;
      r_cur   <= '0;
      r_lrck  <= 1'b0;
      r_sdata <= 1'b0;
      r_und   <= 1'b0;
    end else begin
      r_und <= 1'b0;
      if (w_tc) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      if (w_fall) begin
        r_f    <= w_f_nx;
        r_lrck <= w_f_nx[FRAME_W-1];
        if (w_fetch) begin
          if (w_level != 2'd0) begin
            r_cur   <= w_head;
            r_sdata <= w_head[SLOT_BITS-1];
          end else begin
            r_und   <= 1'b1;
            r_sdata <= r_cur[SAMPLE_W-1];
          end
        end else begin
          r_sdata <= r_cur[bit_sel(w_f_nx)];
        end
      end
    end
  end

  assign i2s_bclk   = r_bclk;
  assign i2s_lrck   = r_lrck;
  assign i2s_sdata  = r_sdata;
  assign fifo_level = w_level;
  assign underrun   = r_und;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Testbench for sid_i2s_tx: timing/stream model
// plus directed tables and corner sequences.
module tb_sid_i2s_tx;
  import sid_audio_pkg::*;

  localparam int CD  = 4;
  localparam int CD2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic clr = 1'b0;

  logic       bclk, lrck, sdata, ovf, und;
  logic [1:0] lvl;
  logic       bclk2, lrck2, sdata2, ovf2, und2;
  logic [1:0] lvl2;

  int checks = 0;
  int errors = 0;

  sid_i2s_tx_if bus ();
  sid_i2s_tx_if bus2 ();

  always #5 clk = ~clk;

  sid_i2s_tx #(.CLK_DIV(CD), .SAMPLE_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_in       (bus),
    .enable     (en),
    .ovf_clr    (clr),
    .i2s_bclk   (bclk),
    .i2s_lrck   (lrck),
    .i2s_sdata  (sdata),
    .fifo_level (lvl),
    .overflow   (ovf),
    .underrun   (und)
  );

  sid_i2s_tx #(.CLK_DIV(CD2), .SAMPLE_W(16)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .s_in       (bus2),
    .enable     (en),
    .ovf_clr    (1'b0),
    .i2s_bclk   (bclk2),
    .i2s_lrck   (lrck2),
    .i2s_sdata  (sdata2),
    .fifo_level (lvl2),
    .overflow   (ovf2),
    .underrun   (und2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: enabled-cycle count gives the whole timing
  int unsigned   cnt = 0;
  logic [15:0]   q[$];
  logic [15:0]   m_cur = 16'h0;
  logic          m_ovf = 1'b0;
  logic          m_und = 1'b0;

  always @(posedge clk) begin
    logic set;
    m_und = 1'b0;
    set   = 1'b0;
    if (rst) begin
      cnt = 0;
      q.delete();
      m_cur = 16'h0;
      m_ovf = 1'b0;
    end else begin
      if (!en) begin
        cnt   = 0;
        m_cur = 16'h0;
      end else begin
        cnt++;
        if ((cnt % (2*CD)) == 0 && ((cnt / (2*CD)) % 32) == 1) begin
          if (q.size() > 0) m_cur = q.pop_front();
          else              m_und = 1'b1;
        end
      end
      if (bus.sample_valid) begin
        if (q.size() == 2) begin
          q[1] = bus.sample_in;
          set  = 1'b1;
        end else begin
          q.push_back(bus.sample_in);
        end
      end
      if (set)      m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
  end

  logic [1:0] cap[$];
  logic       pb;
  int         und_seen = 0;

  always @(negedge clk) begin
    int   k, f, k2, f2;
    logic eb, el, es;
    k  = int'(cnt) / (2*CD);
    f  = k % 32;
    eb = ((int'(cnt) / CD) % 2) == 1;
    el = (f >= 16);
    es = (k == 0) ? 1'b0 : m_cur[15 - ((f + 15) % 16)];
    chk("stream", 32'({bclk, lrck, sdata, und, lvl, ovf}),
        32'({eb, el, es, m_und, 2'(q.size()), m_ovf}));
    k2 = int'(cnt) / (2*CD2);
    f2 = k2 % 32;
    chk("stream_div2", 32'({bclk2, lrck2, sdata2, lvl2, ovf2}),
        32'({(((int'(cnt) / CD2) % 2) == 1), (f2 >= 16), 1'b0, 2'b00, 1'b0}));
    if (pb === 1'b1 && bclk === 1'b0) cap.push_back({lrck, sdata});
    if (und === 1'b1) und_seen++;
    pb = bclk;
  end

  task automatic wait_cnt(input int unsigned target, input string nm);
    int g;
    g = 0;
    while (cnt != target && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (cnt != target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, count %0d expected %0d", nm, cnt, target);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return bclk;
      1:       return lrck;
      2:       return bclk2;
      default: return lrck2;
    endcase
  endfunction

  task automatic period(input int s, input int lim, output int p);
    logic prev;
    int   t0;
    int   n;
    p    = -1;
    t0   = -1;
    prev = sig(s);
    for (int c = 0; c < lim && p < 0; c++) begin
      @(negedge clk);
      if (!prev && sig(s)) begin
        if (t0 < 0) t0 = c;
        else        p  = c - t0;
      end
      prev = sig(s);
    end
    n = p;
    p = n;
  endtask

  typedef struct {
    int   f;
    logic lr;
    logic sd;
  } slot_t;

  typedef struct {
    string       nm;
    logic        sv;
    logic [15:0] d;
    logic        cl;
    logic [1:0]  lv;
    logic        ov;
  } step_t;

  slot_t tab2[32];
  step_t tab4[6];

  initial begin
    logic [15:0] w;
    int          p;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
    w = 16'h0;
    p = 0;
  end

  initial begin
    logic [15:0] w;
    int          p;
    w = 16'hA5C3;
    for (int i = 0; i < 32; i++) begin
      tab2[i].f  = (i + 1) % 32;
      tab2[i].lr = (tab2[i].f >= 16);
      tab2[i].sd = w[15 - (i % 16)];
    end
    tab4[0] = '{"push1",      1'b1, 16'h0001, 1'b0, 2'd1, 1'b0};
    tab4[1] = '{"push2",      1'b1, 16'h0002, 1'b0, 2'd2, 1'b0};
    tab4[2] = '{"push3_full", 1'b1, 16'h0003, 1'b0, 2'd2, 1'b1};
    tab4[3] = '{"ovf_clr",    1'b0, 16'h0000, 1'b1, 2'd2, 1'b0};
    tab4[4] = '{"clr_vs_set", 1'b1, 16'h0004, 1'b1, 2'd2, 1'b1};
    tab4[5] = '{"ovf_clr2",   1'b0, 16'h0000, 1'b1, 2'd2, 1'b0};

    bus.sample_valid  = 1'b0;
    bus.sample_in     = 16'h0;
    bus2.sample_valid = 1'b0;
    bus2.sample_in    = 16'h0;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({bclk, lrck, sdata, und, lvl, ovf}), 32'h0);
    rst = 1'b0;
    cap.delete();
    und_seen = 0;
    @(negedge clk);
    chk("after_release", 32'({bclk, lrck, sdata, und, lvl, ovf}), 32'h0);

    bus.sample_in    = 16'hA5C3;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    chk("level_after_push", 32'(lvl), 32'd1);

    wait_cnt(260, "frame1");
    chk("cap_count", 32'(cap.size() >= 32), 32'd1);
    for (int i = 0; i < 32 && i < cap.size(); i++)
      chk($sformatf("slot_f%0d", tab2[i].f), 32'(cap[i]), 32'({tab2[i].lr, tab2[i].sd}));
    chk("no_underrun_frame1", 32'(und_seen), 32'd0);

    wait_cnt(524, "repeat_frames");
    chk("underrun_pulses", 32'(und_seen), 32'd2);

    for (int i = 0; i < 6; i++) begin
      bus.sample_valid = tab4[i].sv;
      bus.sample_in    = tab4[i].d;
      clr              = tab4[i].cl;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      clr              = 1'b0;
      chk({tab4[i].nm, "_level"}, 32'(lvl), 32'(tab4[i].lv));
      chk({tab4[i].nm, "_ovf"}, 32'(ovf), 32'(tab4[i].ov));
    end

    wait_cnt(775, "pre_fetch");
    bus.sample_in    = 16'h8000;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    chk("pushpop_full_level", 32'(lvl), 32'd2);
    chk("pushpop_full_ovf", 32'(ovf), 32'd0);
    chk("pushpop_full_und", 32'(und), 32'd0);
    chk("pushpop_sdata_msb", 32'(sdata), 32'd0);

    wait_cnt(840, "f9");
    en = 1'b0;
    @(negedge clk);
    chk("disable_outputs", 32'({bclk, lrck, sdata}), 32'h0);
    chk("disable_level", 32'(lvl), 32'd2);
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_cnt(8, "reenable_fetch");
    chk("reenable_level", 32'(lvl), 32'd1);
    chk("reenable_und", 32'(und), 32'd0);
    chk("reenable_lrck", 32'(lrck), 32'd0);

    period(0, 100, p);
    chk("bclk_period", 32'(p), 32'd8);
    period(2, 100, p);
    chk("bclk2_period", 32'(p), 32'd4);
    period(1, 1000, p);
    chk("lrck_period", 32'(p), 32'd256);
    period(3, 1000, p);
    chk("lrck2_period", 32'(p), 32'd128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
